// File: rtl/div_seq.sv
// Iterative radix-2 non-restoring divider: one quotient bit per clock, signed or unsigned
// per operation, start/busy/done handshake with divide-by-zero detection.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iSigned,
   input  logic [WIDTH-1:0] iDividend,
   input  logic [WIDTH-1:0] iDivisor,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oQ,
   output logic [WIDTH-1:0] oR,
   output logic             oDivZero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH:0]   pr;       // signed partial remainder
   logic [WIDTH:0]   dvs;      // divisor magnitude, zero-extended
   logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
   logic [CW-1:0]    cnt;
   logic             qneg, rneg;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   pr_shl, pr_step;
   logic [WIDTH-1:0] rmag;

   // Negating MIN wraps to the same bit pattern, which read unsigned is 2^(WIDTH-1).
   assign a_neg = iSigned & iDividend[WIDTH-1];
   assign b_neg = iSigned & iDivisor[WIDTH-1];
   assign a_mag = a_neg ? -iDividend : iDividend;
   assign b_mag = b_neg ? -iDivisor : iDivisor;

   // Intermediate 2r+b can exceed WIDTH+1 bits, but the post-add/sub value lies in
   // [-D, D) so the modular result is exact.
   assign pr_shl  = {pr[WIDTH-1:0], dvd[WIDTH-1]};
   assign pr_step = pr[WIDTH] ? pr_shl + dvs : pr_shl - dvs;
   assign rmag    = pr[WIDTH] ? pr[WIDTH-1:0] + dvs[WIDTH-1:0] : pr[WIDTH-1:0];

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state    <= IDLE;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oQ       <= '0;
         oR       <= '0;
         oDivZero <= 1'b0;
         pr       <= '0;
         dvs      <= '0;
         dvd      <= '0;
         cnt      <= '0;
         qneg     <= 1'b0;
         rneg     <= 1'b0;
      end else begin
         oDone <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (!iStart) begin
                  state <= IDLE;
               end else if (iDivisor == '0) begin
                  oQ       <= '1;
                  oR       <= iDividend;
                  oDivZero <= 1'b1;
                  oDone    <= 1'b1;
                  state    <= DONE;
               end else begin
                  pr    <= '0;
                  dvd   <= a_mag;
                  dvs   <= {1'b0, b_mag};
                  qneg  <= a_neg ^ b_neg;
                  rneg  <= a_neg;
                  cnt   <= CW'(WIDTH);
                  oBusy <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               pr  <= pr_step;
               dvd <= {dvd[WIDTH-2:0], ~pr_step[WIDTH]};
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               oQ       <= qneg ? -dvd : dvd;
               oR       <= rneg ? -rmag : rmag;
               oDivZero <= 1'b0;
               oDone    <= 1'b1;
               oBusy    <= 1'b0;
               state    <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
